alu_iter: RTL

- Parametrised, handshaked successor to the single-cycle datapath ALU.
- Executes the shared alu_functions_t operations on WIDTH-bit operands and returns a result plus Z/C/V/N flags.
- Adds variable-amount shifts, iterated one bit per cycle; an optional shift-add multiply can be compiled in.
- Sits between the operand-select muxes (Op1/Op2) and the writeback mux. It is driven by the control FSM through a valid/ready pair on each side.

---
 rtl/alu_iter_pkg.sv | 48 ++++
 rtl/alu_iter_addsub.sv | 20 ++
 rtl/alu_iter.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_iter_pkg.sv
// Shared ALU definitions: function codes, iterative-ALU states and flag bit positions.
// FnMUL is only executed when the block is built with ALU_ITER_MUL_EN.
package alu_iter_pkg;

    typedef enum logic [4:0] {
        FnNOP  = 5'd0,
        FnMEM  = 5'd1,
        FnIMM  = 5'd2,
        FnADD  = 5'd3,
        FnADC  = 5'd4,
        FnSUB  = 5'd5,
        FnSUC  = 5'd6,
        FnNEG  = 5'd7,
        FnAND  = 5'd8,
        FnOR   = 5'd9,
        FnXOR  = 5'd10,
        FnNOT  = 5'd11,
        FnNAND = 5'd12,
        FnNOR  = 5'd13,
        FnLSL  = 5'd14,
        FnLSR  = 5'd15,
        FnASR  = 5'd16,
        FnMUL  = 5'd17
    } alu_functions_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } alu_iter_state_t;

    localparam int FLAGS_Z = 0;
    localparam int FLAGS_C = 1;
    localparam int FLAGS_V = 2;
    localparam int FLAGS_N = 3;

    function automatic logic [3:0] pack_flags(input logic z, input logic c,
                                              input logic v, input logic n);
        logic [3:0] f;
        f          = 4'b0000;
        f[FLAGS_Z] = z;
        f[FLAGS_C] = c;
        f[FLAGS_V] = v;
        f[FLAGS_N] = n;
        return f;
    endfunction

endpackage

// File: rtl/alu_iter_addsub.sv
// Combinational WIDTH-bit adder with carry-out and signed overflow of its own inputs.
module alu_iter_addsub #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             ci,
    output logic [WIDTH-1:0] sum,
    output logic             co,
    output logic             ov
);

    logic [WIDTH:0] full_s;

    assign full_s = {1'b0, x} + {1'b0, y} + {{WIDTH{1'b0}}, ci};
    assign sum    = full_s[WIDTH-1:0];
    assign co     = full_s[WIDTH];
    assign ov     = (x[WIDTH-1] == y[WIDTH-1]) && (sum[WIDTH-1] != x[WIDTH-1]);

endmodule

// File: rtl/alu_iter.sv
// Handshaked iterative ALU: single-cycle ops, bit-serial shifts, optional shift-add
// multiply (compile with ALU_ITER_MUL_EN to build FnMUL).
module alu_iter
    import alu_iter_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4:0]       func,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [3:0]       flags
);

    localparam int SHW = $clog2(WIDTH);
    localparam int CW  = SHW + 1;

    alu_iter_state_t state_r;
    logic [4:0]       func_r;
    logic [WIDTH-1:0] a_r, b_r;
    logic             cin_r, carry_r;
    logic [CW-1:0]    cnt_r;

    logic             busy_s, accept_s;
    logic [CW-1:0]    start_cnt_s;
    logic [4:0]       sel_func_s;
    logic [WIDTH-1:0] sel_a_s, sel_b_s, work_a_s, nxt_a_s;
    logic             sel_cin_s, work_c_s, nxt_c_s;
    logic [WIDTH-1:0] add_x_s, add_y_s, add_sum_s, res_s;
    logic             add_ci_s, add_co_s, add_ov_s, res_c_s, res_v_s;
    logic [3:0]       flags_s;
`ifdef ALU_ITER_MUL_EN
    logic [WIDTH-1:0] acc_r, nxt_acc_s, nxt_b_s;
    logic [WIDTH:0]   mul_sum_s;
`endif

    assign busy_s    = (state_r == BUSY);
    assign in_ready  = (state_r == IDLE) || ((state_r == DONE) && out_ready);
    assign accept_s  = in_valid && in_ready;

    // Once busy, operands come from the latched copies; in IDLE straight from the ports.
    assign sel_func_s = busy_s ? func_r   : func;
    assign sel_a_s    = busy_s ? work_a_s : a;
    assign sel_b_s    = busy_s ? b_r      : b;
    assign sel_cin_s  = busy_s ? cin_r    : cin;
    // cnt_r==0 in BUSY means "finalise only": an op re-accepted from DONE takes no step.
    assign work_a_s   = (cnt_r != {CW{1'b0}}) ? nxt_a_s : a_r;
    assign work_c_s   = (cnt_r != {CW{1'b0}}) ? nxt_c_s : carry_r;

    // Iteration count for a new request: shift amount, WIDTH for multiply, else none.
    always_comb begin
        start_cnt_s = {CW{1'b0}};
        case (func)
            FnLSL, FnLSR, FnASR: start_cnt_s = {1'b0, b[SHW-1:0]};
`ifdef ALU_ITER_MUL_EN
            FnMUL:               start_cnt_s = CW'(WIDTH);
`endif
            default:             start_cnt_s = {CW{1'b0}};
        endcase
    end

    // One-bit shift step of the working operand, capturing the bit shifted out.
    always_comb begin
        nxt_a_s = a_r;
        nxt_c_s = carry_r;
        case (func_r)
            FnLSL: begin
                nxt_a_s = {a_r[WIDTH-2:0], 1'b0};
                nxt_c_s = a_r[WIDTH-1];
            end
            FnLSR: begin
                nxt_a_s = {1'b0, a_r[WIDTH-1:1]};
                nxt_c_s = a_r[0];
            end
            FnASR: begin
                nxt_a_s = {a_r[WIDTH-1], a_r[WIDTH-1:1]};
                nxt_c_s = a_r[0];
            end
            default: begin
                nxt_a_s = a_r;
                nxt_c_s = carry_r;
            end
        endcase
    end

`ifdef ALU_ITER_MUL_EN
    // Shift-add step: {acc_r, b_r} is the product register, b_r's LSB picks the add.
    always_comb begin
        mul_sum_s = b_r[0] ? {add_co_s, add_sum_s} : {1'b0, acc_r};
        if (func_r == FnMUL) begin
            nxt_acc_s = mul_sum_s[WIDTH:1];
            nxt_b_s   = {mul_sum_s[0], b_r[WIDTH-1:1]};
        end else begin
            nxt_acc_s = acc_r;
            nxt_b_s   = b_r;
        end
    end
`endif

    // Adder operand steering shared by the arithmetic ops and the multiply accumulate.
    always_comb begin
        add_x_s  = sel_a_s;
        add_y_s  = sel_b_s;
        add_ci_s = 1'b0;
        case (sel_func_s)
            FnADC: add_ci_s = sel_cin_s;
            FnSUB: begin
                add_y_s  = ~sel_b_s;
                add_ci_s = 1'b1;
            end
            FnSUC: begin
                add_y_s  = ~sel_b_s;
                add_ci_s = sel_cin_s;
            end
            FnNEG: begin
                add_x_s  = {WIDTH{1'b0}};
                add_y_s  = ~sel_a_s;
                add_ci_s = 1'b1;
            end
`ifdef ALU_ITER_MUL_EN
            FnMUL: begin
                add_x_s = acc_r;
                add_y_s = a_r;
            end
`endif
            default: add_ci_s = 1'b0;
        endcase
    end

    alu_iter_addsub #(.WIDTH(WIDTH)) u_addsub (
        .x   (add_x_s),
        .y   (add_y_s),
        .ci  (add_ci_s),
        .sum (add_sum_s),
        .co  (add_co_s),
        .ov  (add_ov_s)
    );

    // Result and flag selection; unknown codes fall through to NOP.
    always_comb begin
        res_s   = {WIDTH{1'b0}};
        res_c_s = 1'b0;
        res_v_s = 1'b0;
        case (sel_func_s)
            FnMEM:  res_s = sel_a_s;
            FnIMM:  res_s = sel_b_s;
            FnADD, FnADC, FnSUB, FnSUC, FnNEG: begin
                res_s   = add_sum_s;
                res_c_s = add_co_s;
                res_v_s = add_ov_s;
            end
            FnAND:  res_s = sel_a_s & sel_b_s;
            FnOR:   res_s = sel_a_s | sel_b_s;
            FnXOR:  res_s = sel_a_s ^ sel_b_s;
            FnNOT:  res_s = ~sel_a_s;
            FnNAND: res_s = ~(sel_a_s & sel_b_s);
            FnNOR:  res_s = ~(sel_a_s | sel_b_s);
            FnLSL, FnLSR, FnASR: begin
                res_s   = sel_a_s;
                res_c_s = busy_s ? work_c_s : 1'b0;
            end
`ifdef ALU_ITER_MUL_EN
            FnMUL: begin
                res_s   = nxt_b_s;
                res_c_s = |nxt_acc_s;
            end
`endif
            default: res_s = {WIDTH{1'b0}};
        endcase
        flags_s = pack_flags(res_s == {WIDTH{1'b0}}, res_c_s, res_v_s, res_s[WIDTH-1]);
    end

    // Control FSM with operand latches and registered result/flags/valid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= IDLE;
            func_r    <= 5'd0;
            a_r       <= {WIDTH{1'b0}};
            b_r       <= {WIDTH{1'b0}};
            cin_r     <= 1'b0;
            carry_r   <= 1'b0;
            cnt_r     <= {CW{1'b0}};
            out_valid <= 1'b0;
            result    <= {WIDTH{1'b0}};
            flags     <= 4'b0000;
`ifdef ALU_ITER_MUL_EN
            acc_r     <= {WIDTH{1'b0}};
`endif
        end else begin
            if (accept_s) begin
                func_r  <= func;
                a_r     <= a;
                b_r     <= b;
                cin_r   <= cin;
                carry_r <= 1'b0;
                cnt_r   <= start_cnt_s;
`ifdef ALU_ITER_MUL_EN
                acc_r   <= {WIDTH{1'b0}};
`endif
            end
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        if (start_cnt_s != {CW{1'b0}}) begin
                            state_r <= BUSY;
                        end else begin
                            state_r   <= DONE;
                            result    <= res_s;
                            flags     <= flags_s;
                            out_valid <= 1'b1;
                        end
                    end
                end
                BUSY: begin
                    if (cnt_r != {CW{1'b0}}) begin
                        a_r     <= nxt_a_s;
                        carry_r <= nxt_c_s;
                        cnt_r   <= cnt_r - CW'(1);
`ifdef ALU_ITER_MUL_EN
                        acc_r   <= nxt_acc_s;
                        b_r     <= nxt_b_s;
`endif
                    end
                    if (cnt_r <= CW'(1)) begin
                        state_r   <= DONE;
                        result    <= res_s;
                        flags     <= flags_s;
                        out_valid <= 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state_r   <= in_valid ? BUSY : IDLE;
                    end
                end
                default: state_r <= IDLE;
            endcase
        end
    end

endmodule
